// File: rtl/puf_pkg.sv
// Shared types and constants for the delay-PUF challenge driver and its LFSR.
package puf_pkg;

    localparam int          CHAL_W_DEF   = 16;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a mask on a right-shifting register.
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        FIRE   = 3'd2,
        SAMP   = 3'd3,
        OUT    = 3'd4,
        FIN    = 3'd5
    } state_t;

endpackage

// File: rtl/puf_lfsr16.sv
// 16-bit Fibonacci LFSR with load, advance and zero-seed substitution.
module puf_lfsr16
    import puf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_advance,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            // An all-zero state would lock the register, so substitute a fixed seed.
            r_state <= (i_seed == 16'h0000) ? DEFAULT_SEED : i_seed;
        end else if (i_advance) begin
            r_state <= {w_fb, r_state[15:1]};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/puf_challenge_driver.sv
// Delay-PUF initiator: drives challenges, fires excite, majority-votes the
// synchronized response and streams packed words out over valid/ready.
module puf_challenge_driver
    import puf_pkg::*;
#(
    parameter int CHAL_W     = CHAL_W_DEF,
    parameter int RESP_W     = 16,
    parameter int SETTLE_CYC = 8,
    parameter int EVAL_CYC   = 4,
    parameter int VOTES      = 5
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] seed,
    input  logic [7:0]        num_words,
    output logic              busy,
    output logic              done,
    output logic [CHAL_W-1:0] challenge,
    output logic              excite_l,
    output logic              excite_r,
    input  logic              puf_response,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [7:0]        flaky_cnt,
    output logic [2:0]        o_dbg_state
);

    localparam int BIT_W = $clog2(RESP_W);

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_cyc;
    logic [3:0]        r_vote_idx;
    logic [3:0]        r_ones;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [7:0]        r_words_left;
    logic [RESP_W-1:0] r_data;
    logic [7:0]        r_flaky;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_excite;
    logic [3:0]        w_ones_total;
    logic              w_bit;
    logic              w_flaky;
    logic              w_resolve;
    logic              w_start_acc;
    logic              w_last_bit;

    assign w_start_acc  = (r_state == IDLE) && start;
    assign w_ones_total = r_ones + 4'(r_sync2);
    assign w_bit        = (w_ones_total > 4'(VOTES / 2));
    assign w_flaky      = (w_ones_total != 4'd0) && (w_ones_total != 4'(VOTES));
    assign w_resolve    = (r_state == SAMP) && (r_vote_idx == 4'(VOTES - 1));
    assign w_last_bit   = (r_bit_idx == BIT_W'(RESP_W - 1));

    puf_lfsr16 u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_start_acc),
        .i_advance (w_resolve),
        .i_seed    (seed),
        .o_state   (challenge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = (num_words == 8'd0) ? FIN : SETTLE;
            SETTLE:  if (r_cyc == 8'(SETTLE_CYC - 1)) w_next_state = FIRE;
            FIRE:    if (r_cyc == 8'(EVAL_CYC - 1)) w_next_state = SAMP;
            SAMP:    w_next_state = (w_resolve && w_last_bit) ? OUT : SETTLE;
            // Stream handshake: a word moves when resp_valid and resp_ready are both
            // high at a rising edge; resp_data is held stable while valid is waiting.
            OUT:     if (resp_ready) w_next_state = (r_words_left == 8'd1) ? FIN : SETTLE;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != IDLE);
        done       = (r_state == FIN);
        resp_valid = (r_state == OUT);
    end

    // Excite is registered off the next state so both legs switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_excite <= 1'b0;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
        end else begin
            r_excite <= (w_next_state == FIRE);
            r_sync1  <= puf_response;
            r_sync2  <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc        <= '0;
            r_vote_idx   <= '0;
            r_ones       <= '0;
            r_bit_idx    <= '0;
            r_words_left <= '0;
            r_data       <= '0;
            r_flaky      <= '0;
        end else begin
            r_cyc <= (w_next_state != r_state) ? 8'd0 : r_cyc + 8'd1;
            if (w_start_acc) begin
                r_words_left <= num_words;
                r_flaky      <= '0;
                r_vote_idx   <= '0;
                r_ones       <= '0;
                r_bit_idx    <= '0;
            end else if (r_state == SAMP) begin
                if (!w_resolve) begin
                    r_ones     <= w_ones_total;
                    r_vote_idx <= r_vote_idx + 4'd1;
                end else begin
                    r_ones            <= '0;
                    r_vote_idx        <= '0;
                    r_data[r_bit_idx] <= w_bit;
                    r_bit_idx         <= w_last_bit ? '0 : r_bit_idx + 1'b1;
                    if (w_flaky && (r_flaky != 8'hFF)) r_flaky <= r_flaky + 8'd1;
                end
            end else if ((r_state == OUT) && resp_ready) begin
                r_words_left <= r_words_left - 8'd1;
            end
        end
    end

    assign excite_l    = r_excite;
    assign excite_r    = r_excite;
    assign resp_data   = r_data;
    assign flaky_cnt   = r_flaky;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Bench for puf_challenge_driver: behavioural PUF, per-challenge vote model,
// word scoreboard and excite/handshake protocol monitor.
module tb_puf_challenge_driver;

    localparam int CHAL_W     = 16;
    localparam int RESP_W     = 16;
    localparam int SETTLE_CYC = 8;
    localparam int EVAL_CYC   = 4;
    localparam int VOTES      = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CHAL_W-1:0] seed;
    logic [7:0]        num_words;
    logic              busy, done, excite_l, excite_r, resp_valid;
    logic [CHAL_W-1:0] challenge;
    logic              puf_response;
    logic [RESP_W-1:0] resp_data;
    logic              resp_ready;
    logic [7:0]        flaky_cnt;
    logic [2:0]        dbg_state;

    puf_challenge_driver #(
        .CHAL_W(CHAL_W), .RESP_W(RESP_W), .SETTLE_CYC(SETTLE_CYC),
        .EVAL_CYC(EVAL_CYC), .VOTES(VOTES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .seed         (seed),
        .num_words    (num_words),
        .busy         (busy),
        .done         (done),
        .challenge    (challenge),
        .excite_l     (excite_l),
        .excite_r     (excite_r),
        .puf_response (puf_response),
        .resp_data    (resp_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .flaky_cnt    (flaky_cnt),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [RESP_W-1:0] exp_q[$];
    logic [15:0]       exp_chal[$];
    int                exp_flaky;
    bit                thr_mode = 1'b0;
    int                thr_k    = 0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[16-16] ^ s[16-14] ^ s[16-13] ^ s[16-11];
        return {fb, s[15:1]};
    endfunction

    // Behavioural PUF: parity of the challenge, except that in threshold mode the
    // first challenge of a run answers 1 on exactly its first thr_k evaluations.
    function automatic logic model_vote(input int ci, input int v, input logic [15:0] c);
        if (thr_mode && ci == 0) return (v < thr_k);
        return ^c;
    endfunction

    int m_pulse;
    int p_pulse;

    task automatic plan(input logic [15:0] sd, input int nw);
        logic [15:0]       c;
        logic [RESP_W-1:0] w;
        int                ones;
        exp_q.delete();
        exp_chal.delete();
        exp_flaky = 0;
        m_pulse   = 0;
        p_pulse   = 0;
        c = (sd == 16'h0000) ? 16'hACE1 : sd;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int b = 0; b < RESP_W; b++) begin
                exp_chal.push_back(c);
                ones = 0;
                for (int v = 0; v < VOTES; v++) ones += int'(model_vote(wi * RESP_W + b, v, c));
                w[b] = (ones * 2 > VOTES);
                if (ones > 0 && ones < VOTES && exp_flaky < 255) exp_flaky++;
                c = lfsr_next(c);
            end
            exp_q.push_back(w);
        end
    endtask

    // ---------------- behavioural PUF ----------------
    logic p_prev = 1'b0;
    always @(negedge clk) begin
        if (excite_l) puf_response = model_vote(p_pulse / VOTES, p_pulse % VOTES, challenge);
        else          puf_response = 1'b0;
        if (p_prev && !excite_l) p_pulse++;
        p_prev = excite_l;
    end

    // ---------------- monitor / scoreboard ----------------
    bit                mon_en = 1'b0;
    logic              m_prev;
    int                low_run, width;
    logic [15:0]       rise_chal;
    logic              v_prev, r_prev;
    logic [RESP_W-1:0] d_prev, last_word;
    int                busy_cyc, done_cnt;

    always @(negedge clk) begin
        if (!mon_en) begin
            m_prev  = 1'b0;
            v_prev  = 1'b0;
            r_prev  = 1'b0;
            low_run = SETTLE_CYC;
        end else begin
            check("exc_lr", excite_r, excite_l);
            if (excite_l && !m_prev) begin
                check("settle_len", low_run >= SETTLE_CYC, 1);
                rise_chal = challenge;
                width     = 1;
                if (m_pulse / VOTES < exp_chal.size())
                    check("chal_seq", challenge, exp_chal[m_pulse / VOTES]);
                else
                    check("pulse_extra", m_pulse / VOTES, exp_chal.size());
            end else if (excite_l) begin
                width++;
                check("fire_chal", challenge, rise_chal);
            end else if (m_prev) begin
                check("pulse_w", width, EVAL_CYC);
                check("samp_chal", challenge, rise_chal);
                m_pulse++;
                low_run = 1;
            end else begin
                low_run++;
            end
            if (resp_valid) check("out_exc", excite_l, 0);
            if (v_prev && !r_prev) begin
                check("valid_hold", resp_valid, 1);
                check("data_hold", resp_data, d_prev);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() > 0) begin
                    check("word", resp_data, exp_q.pop_front());
                    last_word = resp_data;
                end else begin
                    check("word_extra", exp_q.size(), 1);
                end
            end
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            m_prev = excite_l;
            v_prev = resp_valid;
            r_prev = resp_ready;
            d_prev = resp_data;
        end
    end

    // ---------------- driver tasks ----------------
    logic [15:0] first_chal;

    task automatic run_job(input logic [15:0] sd, input logic [7:0] nw, input int exp_busy);
        int n;
        int budget;
        plan(sd, int'(nw));
        busy_cyc = 0;
        done_cnt = 0;
        @(negedge clk);
        seed = sd; num_words = nw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_chal = challenge;
        if (nw != 8'd0) check("chal_load", challenge, exp_chal[0]);
        budget = int'(nw) * 1200 + 400;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        @(negedge clk);
        check("done_pulse", done_cnt, 1);
        check("busy_clr", busy, 0);
        check("done_clr", done, 0);
        check("words_left", exp_q.size(), 0);
        check("flaky", flaky_cnt, exp_flaky);
        if (exp_busy >= 0) check("busy_len", busy_cyc, exp_busy);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 resp_ready = v;
    endtask

    // ---------------- test sequence ----------------
    int   ks[3] = '{3, 2, 5};
    bit   rr_on;
    logic [15:0] g_chal;
    logic [15:0] rs;
    int   n;

    initial begin
        rst_n = 1'b0; start = 1'b0; seed = '0; num_words = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_exc", {excite_l, excite_r}, 0);
        check("rst_chal", challenge, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_data", resp_data, 0);
        check("rst_flaky", flaky_cnt, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Single word, parity PUF: 16 bits x 65 cycles, one OUT cycle, one FIN cycle.
        run_job(16'h0001, 8'd1, RESP_W * VOTES * (SETTLE_CYC + EVAL_CYC + 1) + 2);

        // Backpressure on the first of two words, with an ignored start mid-run.
        resp_ready = 1'b0;
        rs = 16'($urandom_range(1, 65535));
        fork
            run_job(rs, 8'd2, -1);
            begin
                n = 0;
                while (!resp_valid && n < 3000) begin @(negedge clk); n++; end
                check("bp_valid_seen", resp_valid, 1);
                repeat (50) @(posedge clk);
                #2 resp_ready = 1'b1;
            end
            begin
                repeat (3) @(negedge clk);
                n = 0;
                while (!(m_pulse >= 3 && excite_l) && n < 3000) begin @(negedge clk); n++; end
                g_chal = challenge;
                seed = 16'h1234; num_words = 8'd9; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("gate_busy", busy, 1);
                check("gate_chal", challenge, g_chal);
            end
        join

        // Zero length, then zero seed.
        run_job(16'h5A5A, 8'd0, 1);
        check("zl_no_exc", m_pulse, 0);
        run_job(16'h0000, 8'd1, 1042);
        check("seed0_chal", first_chal, 16'hACE1);

        // Voting thresholds on the first challenge.
        thr_mode = 1'b1;
        foreach (ks[i]) begin
            thr_k = ks[i];
            run_job(16'($urandom_range(1, 65535)), 8'd1, 1042);
            check("thr_bit0", last_word[0], (ks[i] >= 3) ? 1 : 0);
            check("thr_flaky", flaky_cnt, (ks[i] == VOTES) ? 0 : 1);
        end
        thr_mode = 1'b0;

        // Random ready throttling over two words.
        rr_on = 1'b1;
        fork
            begin
                run_job(16'($urandom), 8'd2, -1);
                rr_on = 1'b0;
            end
            begin
                while (rr_on) begin
                    @(posedge clk);
                    #2 resp_ready = 1'($urandom_range(0, 1));
                end
                set_ready(1'b1);
            end
        join

        // Asynchronous reset during FIRE of bit 7.
        rs = 16'($urandom_range(1, 65535));
        plan(rs, 1);
        @(negedge clk);
        seed = rs; num_words = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(m_pulse == 7 * VOTES && excite_l) && n < 5000) begin @(negedge clk); n++; end
        check("rst_reach_fire7", (m_pulse == 7 * VOTES) && excite_l, 1);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_exc_l", excite_l, 0);
        check("arst_exc_r", excite_r, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", resp_valid, 0);
        check("arst_chal", challenge, 0);
        check("arst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        run_job(16'($urandom), 8'd1, 1042);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/puf_challenge_driver.md
Name: puf_challenge_driver

Overview:
- Initiator side of the delay-PUF evaluation interface. Generates a pseudo-random challenge sequence, fires the excite pair, samples the single-bit PUF response and majority-votes repeated evaluations.
- Packs the voted bits into words and returns them over a valid/ready stream.
- Sits between the host/UART command logic and the DAPUF/arbiter-PUF array. It owns all timing of challenge setup and excitation.

Parameters:
- CHAL_W, 16, challenge width; matches the PUF challenge bus.
- RESP_W, 16, voted response bits packed per output word.
- SETTLE_CYC, 8, cycles the challenge is held stable with excite low before each fire; range 1..255.
- EVAL_CYC, 4, cycles excite is held high; minimum 3, to cover the 2-flop synchronizer.
- VOTES, 5, evaluations per challenge; odd, range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only while busy=0
- seed  in  CHAL_W  LFSR seed, captured on an accepted start
- num_words  in  8  response words to produce, captured on an accepted start
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at end of run
- challenge  out  CHAL_W  registered challenge driven to the PUF
- excite_l  out  1  left excite; registered, identical timing to excite_r
- excite_r  out  1  right excite
- puf_response  in  1  asynchronous PUF output
- resp_data  out  RESP_W  packed voted bits; bit 0 is the first challenge evaluated in the word
- resp_valid  out  1  resp_data is valid
- resp_ready  in  1  sink accepts when valid&ready at a rising edge
- flaky_cnt  out  8  count of challenges with non-unanimous votes; cleared on start; saturates at 255

Behaviour:
- Reset, asynchronous: all outputs are 0, FSM returns to IDLE, internal counters and the synchronizer clear. Assertion mid-run aborts immediately; excite drops with no glitch beyond the reset edge.
- Synchronizer: puf_response passes through 2 flops, continuously clocked.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. A seed of 0 is replaced by 16'hACE1. The challenge register is the LFSR state and is loaded on the start edge. It advances only when a bit resolves, never during SETTLE/FIRE.
- FSM states:
  - IDLE: busy=0. On start: capture seed and num_words, clear flaky_cnt, set busy=1. If num_words==0, go to FIN; else go to SETTLE.
  - SETTLE: excite=0 for SETTLE_CYC cycles, then FIRE.
  - FIRE: excite_l=excite_r=1 for EVAL_CYC cycles, then SAMP.
  - SAMP: 1 cycle, excite=0. Add the synced response to the ones-counter.
    - If vote_idx<VOTES-1: increment vote_idx, go to SETTLE with the same challenge.
    - Else: resolve bit = (ones > VOTES/2). Increment flaky_cnt if 0<ones<VOTES. Shift the bit into position bit_idx. Advance the LFSR and clear vote counters.
    - Then, if bit_idx==RESP_W-1, go to OUT; else go to SETTLE.
  - OUT: resp_valid=1; resp_data held stable; no excitation. On valid&ready, decrement words_left and drop resp_valid the next cycle. Go to FIN if words_left reaches 0, else go to SETTLE.
  - FIN: done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
- Cycles per bit: VOTES*(SETTLE_CYC+EVAL_CYC+1). Defaults give 65; 1040 per word plus handshake.
- start while busy=1 is ignored. seed and num_words changes while busy have no effect.
- resp_ready may be high before resp_valid; the transfer still occurs in the first OUT cycle.

Decomposition:
- Shared package puf_pkg holds:
  - the FSM state enum (IDLE, SETTLE, FIRE, SAMP, OUT, FIN)
  - the LFSR tap constant
  - DEFAULT_SEED = 16'hACE1
  - the CHAL_W default
- One sub-module, puf_lfsr16: load, advance, seed-zero substitution. It is reusable by future PUF drivers.

Test Plan:
- Single word, fair model: seed=16'h0001, num_words=1, behavioural PUF response = parity of the challenge while excite is high → resp_data matches the reference model of the first 16 LFSR states; flaky_cnt=0; busy high for 1040 cycles plus handshake; one done pulse.
- Backpressure: num_words=2, resp_ready held low 50 cycles after the first resp_valid → resp_valid and resp_data stable, excite stays 0 throughout, second word follows correctly after ready.
- Zero length and zero seed: num_words=0 → done the cycle after FIN entry, excite never toggles. Then seed=0, num_words=1 → first challenge 16'hACE1.
- Voting thresholds: model returns 1 on exactly 3 of 5 votes for challenge 0 → bit0=1, flaky_cnt=1. Returns 1 on 2 of 5 → bit0=0, flaky_cnt=1. Returns 1 on 5 of 5 → bit=1, flaky_cnt=0.
- Excite timing: check every pulse is EVAL_CYC=4 cycles wide, excite_l==excite_r on every cycle, and challenge is constant from SETTLE entry through SAMP.
- Reset and start gating: rst_n low during FIRE of bit 7 → excite_l/excite_r/busy/resp_valid/challenge all 0 asynchronously. A start pulse while busy=1 is ignored, with no re-seed observed.
